// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the async FIFO: turns the registered pull interface into a
// first-word-fall-through valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            m_level,
    output logic [CNT_WIDTH-1:0]  m_count
);

    logic                  r_run;
    logic                  r_inflight;
    logic                  r_head;
    logic                  r_tail;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_pop;
    logic [1:0]            w_pending;
    logic                  w_room;
    logic [1:0]            w_occ_next;

    // Buffered plus in-flight words never exceed 2, so a 2-bit sum cannot overflow.
    assign w_pop      = (r_occ != 2'd0) && m_ready;
    assign w_pending  = r_occ + {1'b0, r_inflight};
    assign w_room     = (w_pending < 2'd2) || ((w_pending == 2'd2) && w_pop);
    assign fifo_rd_en = r_run && !fifo_empty && w_room;
    assign w_occ_next = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

    // Reads are held off until the first clock edge after reset release.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
            r_occ      <= w_occ_next;
            if (r_inflight) begin
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    // FIFO data is only meaningful the cycle after an accepted read.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else if (r_inflight) begin
            r_mem[r_tail] <= fifo_rd_data;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign m_valid = (r_occ != 2'd0);
    assign m_data  = r_mem[r_head];
    assign m_level = r_occ;
    assign m_count = r_count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized checks of fifo_rd_stream against a timestamped model of
// words read from a behavioural FIFO; a second instance with a 4-bit counter checks wrap.
module tb_fifo_rd_stream;

    typedef struct {
        logic [15:0] d;
        int          rc;
    } entry_t;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        m_ready = 1'b0;
    logic [15:0] fifo_rd_data = 16'h0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  m_level;
    logic [15:0] m_count;
    logic        fifo_rd_en4;
    logic        m_valid4;
    logic [15:0] m_data4;
    logic [1:0]  m_level4;
    logic [3:0]  m_count4;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          expCount = 0;
    bit          expRun = 1'b0;
    int          rdEnHighs = 0;
    int          levelMax = 0;
    logic [15:0] fifoQ[$];
    entry_t      pendQ[$];

    fifo_rd_stream #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_level(m_level), .m_count(m_count)
    );

    fifo_rd_stream #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut4 (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en4), .fifo_rd_data(fifo_rd_data), .m_valid(m_valid4),
        .m_ready(m_ready), .m_data(m_data4), .m_level(m_level4), .m_count(m_count4)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A word read in cycle rc is visible on the stream from cycle rc+2 until popped.
    task automatic checkCycle(output bit expRdEn, output bit expPop);
        int  lvl;
        bit  expValid;
        lvl = 0;
        foreach (pendQ[i]) begin
            if (pendQ[i].rc <= cyc - 2) lvl++;
        end
        expValid = (lvl > 0);
        expPop   = expValid && (m_ready === 1'b1);
        expRdEn  = expRun && !fifo_empty &&
                   ((pendQ.size() < 2) || ((pendQ.size() == 2) && expPop));
        checkOutput("rd_en", fifo_rd_en, expRdEn);
        checkOutput("valid", m_valid, expValid);
        checkOutput("level", m_level, lvl);
        checkOutput("count", m_count, expCount % 65536);
        checkOutput("count4", m_count4, expCount % 16);
        if (expValid) checkOutput("data", m_data, pendQ[0].d);
        if (fifo_rd_en === 1'b1) rdEnHighs++;
        if (int'(m_level) > levelMax) levelMax = int'(m_level);
    endtask

    task automatic applyStimulus(input bit ready, input bit holdEmpty);
        bit expRdEn;
        bit expPop;
        m_ready    = ready;
        fifo_empty = holdEmpty || (fifoQ.size() == 0);
        @(negedge rd_clk);
        checkCycle(expRdEn, expPop);
        @(posedge rd_clk);
        #1;
        if (expPop) begin
            pendQ.delete(0);
            expCount++;
        end
        if (expRdEn && fifoQ.size() > 0) begin
            fifo_rd_data = fifoQ.pop_front();
            pendQ.push_back('{d: fifo_rd_data, rc: cyc});
        end
        cyc++;
        expRun = 1'b1;
    endtask

    task automatic doReset();
        rd_rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", m_valid, 0);
        checkOutput("rst_rd_en", fifo_rd_en, 0);
        checkOutput("rst_level", m_level, 0);
        checkOutput("rst_count", m_count, 0);
        checkOutput("rst_data", m_data, 0);
        checkOutput("rst_count4", m_count4, 0);
        fifoQ.delete();
        pendQ.delete();
        expCount   = 0;
        expRun     = 1'b0;
        fifo_empty = 1'b1;
        @(posedge rd_clk);
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
    endtask

    initial begin
        int budget;
        int base;
        #2;
        doReset();

        // Idle with an empty FIFO.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);

        // Back-to-back streaming of 8 words.
        for (int i = 1; i <= 8; i++) fifoQ.push_back(16'(i));
        rdEnHighs = 0;
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("t2_rd_en_cycles", rdEnHighs, 8);
        checkOutput("t2_count", m_count, 8);

        // Mid-stream stall of 5 cycles.
        for (int i = 0; i < 16; i++) fifoQ.push_back(16'hA000 + 16'(i));
        levelMax = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("t3_stall_level", m_level, 2);
        checkOutput("t3_stall_rd_en", fifo_rd_en, 0);
        for (int i = 0; i < 22; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("t3_level_max", levelMax, 2);
        checkOutput("t3_count", m_count, 24);

        // Random backpressure and FIFO gaps over 200 words.
        for (int i = 0; i < 200; i++) fifoQ.push_back(16'($urandom));
        base = expCount;
        budget = 0;
        while ((fifoQ.size() != 0 || pendQ.size() != 0) && budget < 3000) begin
            applyStimulus(bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            budget++;
        end
        checkOutput("t4_drained", (fifoQ.size() == 0 && pendQ.size() == 0), 1);
        checkOutput("t4_delivered", m_count - 16'(base), 200);

        // Fill to two, then drain while the FIFO runs dry.
        for (int i = 0; i < 3; i++) fifoQ.push_back(16'hC000 + 16'(i));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("t5_full_level", m_level, 2);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("t5_valid_drop", m_valid, 0);
        checkOutput("t5_empty_rd_en", fifo_rd_en, 0);

        // Asynchronous reset with a full buffer, then a counter-wrap run.
        for (int i = 0; i < 4; i++) fifoQ.push_back(16'hD000 + 16'(i));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("t6_pre_level", m_level, 2);
        doReset();
        for (int i = 0; i < 18; i++) fifoQ.push_back(16'hE000 + 16'(i));
        for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("t6_count4_wrap", m_count4, 2);
        checkOutput("t6_count", m_count, 18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
